// File: rtl/delay_rr_scheduler_if.sv
`default_nettype none
// =============================================================================
// Module  : delay_rr_scheduler_if
// Brief   : Request/length/abort inputs and grant/done/monitor outputs of the
//           shared round-robin delay scheduler.
// Revision: 1.0
// =============================================================================
interface delay_rr_scheduler_if #(
  parameter int NREQ  = 4,
  parameter int CBITS = 11
);
  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0]       req;
  logic [NREQ*CBITS-1:0] len;
  logic                  abort;
  logic [NREQ-1:0]       gnt;
  logic                  busy;
  logic                  sig;
  logic [IW-1:0]         sig_id;
  logic                  err;
  logic                  flg;

  modport master (
    output req, len, abort,
    input  gnt, busy, sig, sig_id, err, flg
  );

  modport slave (
    input  req, len, abort,
    output gnt, busy, sig, sig_id, err, flg
  );
endinterface
`default_nettype wire

// File: rtl/delay_rr_scheduler.sv
`default_nettype none
// =============================================================================
// Module  : delay_rr_scheduler
// Brief   : One count-to-limit delay engine shared round-robin among NREQ
//           requesters; fires a one-cycle sig tagged with the winner's index.
// Revision: 1.0
// =============================================================================
module delay_rr_scheduler #(
  parameter int NREQ  = 4,
  parameter int CBITS = 11,
  parameter int DELAY = 1250
) (
  input  wire logic           clk,
  input  wire logic           rst,
  delay_rr_scheduler_if.slave bus_io
);
  localparam int               IW          = $clog2(NREQ);
  localparam logic [CBITS-1:0] C_LIMIT_MAX = CBITS'(DELAY);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CBITS-1:0] cnt_q, cnt_d;
  logic [CBITS-1:0] limit_q, limit_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic             busy_q, busy_d;
  logic             sig_q, sig_d;
  logic [IW-1:0]    sig_id_q, sig_id_d;
  logic             flg_q, flg_d;
  logic             err_q, err_d;

  logic [CBITS-1:0] w_len [NREQ];
  logic [IW-1:0]    w_pos;
  logic [IW-1:0]    w_pick;
  logic             w_found;
  logic [CBITS-1:0] w_lim;
  logic             w_gnt_onehot;
  logic             w_state_legal;

  for (genvar g = 0; g < NREQ; g++) begin : g_len_unpack
    assign w_len[g] = bus_io.len[g*CBITS +: CBITS];
  end

  // Round-robin search starts one past the last granted (or aborted) index.
  always_comb begin
    w_found = 1'b0;
    w_pick  = ptr_q;
    w_pos   = ptr_q;
    for (int k = 1; k <= NREQ; k++) begin
      w_pos = IW'((32'(ptr_q) + 32'(k)) % NREQ);
      if (!w_found && bus_io.req[w_pos]) begin
        w_found = 1'b1;
        w_pick  = w_pos;
      end
    end
    w_lim = (w_len[w_pick] > C_LIMIT_MAX) ? C_LIMIT_MAX : w_len[w_pick];
  end

  assign w_gnt_onehot  = (gnt_q != '0) && ((gnt_q & (gnt_q - NREQ'(1))) == '0);
  assign w_state_legal = (state_q == S_IDLE) || (state_q == S_COUNT) || (state_q == S_DONE);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    limit_d  = limit_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    sig_d    = 1'b0;
    sig_id_d = '0;
    case (state_q)
      S_IDLE: begin
        if (w_found) begin
          state_d = S_COUNT;
          gnt_d   = NREQ'(1) << w_pick;
          ptr_d   = w_pick;
          cnt_d   = '0;
          limit_d = w_lim;
        end
      end
      S_COUNT: begin
        if (bus_io.abort) begin
          state_d = S_IDLE;
          gnt_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q == limit_q) begin
          state_d  = S_DONE;
          sig_d    = 1'b1;
          sig_id_d = ptr_q;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CBITS'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
    flg_d  = (state_d == S_COUNT) && (cnt_d <= limit_d);
    err_d  = err_q
           | ((state_q == S_COUNT) && (cnt_q > limit_q))
           | !w_state_legal
           | ((state_q != S_IDLE) && !w_gnt_onehot);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      limit_q  <= '0;
      ptr_q    <= IW'(NREQ - 1);
      gnt_q    <= '0;
      busy_q   <= 1'b0;
      sig_q    <= 1'b0;
      sig_id_q <= '0;
      flg_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      limit_q  <= limit_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      busy_q   <= busy_d;
      sig_q    <= sig_d;
      sig_id_q <= sig_id_d;
      flg_q    <= flg_d;
      err_q    <= err_d;
    end
  end

  assign bus_io.gnt    = gnt_q;
  assign bus_io.busy   = busy_q;
  assign bus_io.sig    = sig_q;
  assign bus_io.sig_id = sig_id_q;
  assign bus_io.flg    = flg_q;
  assign bus_io.err    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_delay_rr_scheduler.sv
`default_nettype none
// =============================================================================
// Module  : tb_delay_rr_scheduler
// Brief   : Bench for delay_rr_scheduler: timeline model compared every cycle
//           plus directed scenarios with literal expectations.
// Revision: 1.0
// =============================================================================
module tb_delay_rr_scheduler;
  localparam int NREQ  = 4;
  localparam int CBITS = 11;
  localparam int DELAY = 1250;
  localparam int IW    = $clog2(NREQ);
  localparam int BOUND = NREQ * (DELAY + 4);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  delay_rr_scheduler_if #(.NREQ(NREQ), .CBITS(CBITS)) bus ();

  delay_rr_scheduler #(.NREQ(NREQ), .CBITS(CBITS), .DELAY(DELAY)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Model: a grant opens a window of lim+2 cycles measured from the grant;
  // the last cycle of the window carries sig, the earlier ones count.
  bit              m_act = 1'b0;
  int              m_idx = 0;
  int              m_lim = 0;
  int              m_t   = 0;
  int              m_ptr = NREQ - 1;
  int              m_j;
  int              m_l;
  logic [NREQ-1:0] req_s = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_act = 1'b0;
      m_t   = 0;
      m_idx = 0;
      m_ptr = NREQ - 1;
      req_s = '0;
    end else begin
      req_s = bus.req;
      if (m_act) begin
        if (m_t <= m_lim + 1 && bus.abort) m_act = 1'b0;
        else if (m_t == m_lim + 2)         m_act = 1'b0;
        else                               m_t   = m_t + 1;
      end else begin
        for (int k = 1; k <= NREQ; k++) begin
          m_j = (m_ptr + k) % NREQ;
          m_l = int'(bus.len[m_j*CBITS +: CBITS]);
          if (!m_act && bus.req[m_j]) begin
            m_act = 1'b1;
            m_idx = m_j;
            m_lim = (m_l > DELAY) ? DELAY : m_l;
            m_t   = 1;
          end
        end
        if (m_act) m_ptr = m_idx;
      end
    end
  end

  logic [NREQ-1:0] e_gnt;
  logic            e_sig;
  logic            e_flg;
  int              wt [NREQ];

  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) wt[i] = 0;
    end else begin
      e_gnt = m_act ? (NREQ'(1) << m_idx) : '0;
      e_sig = m_act && (m_t == m_lim + 2);
      e_flg = m_act && (m_t <= m_lim + 1);
      checks++;
      if (bus.gnt !== e_gnt || bus.busy !== m_act || bus.sig !== e_sig ||
          bus.flg !== e_flg || bus.err !== 1'b0 ||
          (e_sig && bus.sig_id !== IW'(m_idx))) begin
        errors++;
        $display("FAIL model_cmp cyc=%0d: got gnt=%b busy=%b sig=%b id=%0d flg=%b err=%b, want gnt=%b busy=%b sig=%b id=%0d flg=%b err=0",
                 cyc, bus.gnt, bus.busy, bus.sig, bus.sig_id, bus.flg, bus.err,
                 e_gnt, m_act, e_sig, m_idx, e_flg);
      end
      for (int i = 0; i < NREQ; i++) begin
        if (bus.sig && bus.sig_id == IW'(i)) begin
          if (req_s[i]) begin
            checks++;
            if (wt[i] > BOUND) begin
              errors++;
              $display("FAIL fairness req%0d: got wait %0d, want <= %0d", i, wt[i], BOUND);
            end
          end
          wt[i] = 0;
        end else if (req_s[i]) begin
          wt[i]++;
          if (wt[i] == BOUND + 1) begin
            checks++;
            errors++;
            $display("FAIL starvation req%0d: got wait %0d, want <= %0d", i, wt[i], BOUND);
          end
        end else begin
          wt[i] = 0;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", nm, got, want);
    end
  endtask

  task automatic set_len(input int i, input int v);
    bus.len[i*CBITS +: CBITS] = CBITS'(v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.req   = '0;
    bus.abort = 1'b0;
    #2 rst = 1'b1;
    @(negedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    bus.req   = '0;
    bus.abort = 1'b0;
    do begin
      @(negedge clk);
      n++;
    end while ((bus.busy || bus.gnt != '0) && n < 3000);
    chk("idle_reached", 32'(n < 3000), 1);
    @(negedge clk);
  endtask

  function automatic int idx_of(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  int gidx [5];
  int gcyc [5];
  int scyc [5];
  int exp_order [5] = '{0, 1, 2, 3, 0};
  int ng, ns, lat, g, s;
  logic [NREQ-1:0] prev;

  initial begin
    bus.req   = '0;
    bus.len   = '0;
    bus.abort = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", 32'({bus.gnt, bus.busy, bus.sig, bus.sig_id, bus.flg, bus.err}), 0);
    #2 rst = 1'b0;

    // Single request, len 5
    @(negedge clk);
    set_len(0, 5);
    bus.req = 4'b0001;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) bus.req = '0;
      chk("t1_gnt", 32'(bus.gnt), (k <= 7) ? 1 : 0);
      chk("t1_flg", 32'(bus.flg), (k <= 6) ? 1 : 0);
      chk("t1_sig", 32'(bus.sig), (k == 7) ? 1 : 0);
      if (k == 7) chk("t1_sig_id", 32'(bus.sig_id), 0);
    end
    wait_idle();

    // All four requesting, len 2
    do_reset();
    for (int i = 0; i < NREQ; i++) set_len(i, 2);
    for (int i = 0; i < 5; i++) begin gidx[i] = -1; gcyc[i] = -100; scyc[i] = 100; end
    ng = 0; ns = 0; prev = '0;
    @(negedge clk);
    bus.req = 4'b1111;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (bus.gnt != '0 && prev == '0 && ng < 5) begin gidx[ng] = idx_of(bus.gnt); gcyc[ng] = k; ng++; end
      if (bus.sig && ns < 5) begin scyc[ns] = k; ns++; end
      prev = bus.gnt;
    end
    wait_idle();
    for (int i = 0; i < 5; i++) begin
      chk("t2_order", 32'(gidx[i]), 32'(exp_order[i]));
      chk("t2_sig_after_gnt", 32'(scyc[i] - gcyc[i]), 3);
      if (i > 0) chk("t2_period", 32'(gcyc[i] - gcyc[i-1]), 5);
    end

    // Zero length and clamped length
    set_len(0, 0);
    @(negedge clk);
    bus.req = 4'b0001;
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) bus.req = '0;
      if (bus.sig && lat < 0) lat = k;
    end
    chk("t3_len0_latency", 32'(lat), 2);

    set_len(0, 2000);
    @(negedge clk);
    bus.req = 4'b0001;
    g = -1; s = -1;
    for (int k = 1; k <= 1300 && s < 0; k++) begin
      @(negedge clk);
      if (k == 1) bus.req = '0;
      if (bus.gnt[0] && g < 0) g = k;
      if (bus.sig && s < 0) s = k;
    end
    chk("t3_clamp_latency", 32'(s - g), 1251);
    wait_idle();

    // Abort at cnt=3, then the pointer moves past the aborted index
    set_len(2, 10);
    set_len(3, 1);
    @(negedge clk);
    bus.req = 4'b0100;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) begin chk("t4_gnt", 32'(bus.gnt), 4); bus.req = '0; end
      if (k == 4) begin chk("t4_flg_cnt3", 32'(bus.flg), 1); bus.abort = 1'b1; end
      if (k == 5) begin
        chk("t4_busy_after_abort", 32'(bus.busy), 0);
        chk("t4_gnt_after_abort", 32'(bus.gnt), 0);
        chk("t4_no_sig", 32'(bus.sig), 0);
        bus.abort = 1'b0;
        bus.req   = 4'b1111;
      end
      if (k == 6) begin
        chk("t4_next_grant", 32'(bus.gnt), 8);
        chk("t4_no_sig_late", 32'(bus.sig), 0);
        bus.req = '0;
      end
    end
    wait_idle();

    // Asynchronous reset in the middle of a delay
    set_len(1, 10);
    set_len(2, 3);
    @(negedge clk);
    bus.req = 4'b0010;
    repeat (4) @(negedge clk);
    chk("t5_busy_before_rst", 32'(bus.busy), 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t5_async_clear", 32'({bus.gnt, bus.busy, bus.sig, bus.sig_id, bus.flg, bus.err}), 0);
    @(negedge clk);
    bus.req = 4'b0100;
    #2 rst = 1'b0;
    @(negedge clk);
    chk("t5_first_grant", 32'(bus.gnt), 4);
    wait_idle();

    // Held requests with varied lengths, then random traffic with aborts
    for (int i = 0; i < NREQ; i++) set_len(i, $urandom_range(0, 30));
    bus.req = 4'b1111;
    repeat (400) @(negedge clk);
    wait_idle();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      bus.req   = NREQ'($urandom);
      bus.abort = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 7) == 0) set_len($urandom_range(0, NREQ - 1), $urandom_range(0, 40));
    end
    wait_idle();
    chk("t6_err_clear", 32'(bus.err), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    errors++;
    $display("FAIL watchdog: got timeout, want completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
